// File: rtl/sym_fir_stream.sv
// Symmetric odd-length FIR with valid/ready sample streams and runtime-loadable coefficients.
// One pre-add and one multiply per cycle over the NH unique coefficients, then round/saturate.
module sym_fir_stream #(
  parameter int TAPS  = 73,
  parameter int DW    = 12,
  parameter int CW    = 16,
  parameter int OW    = 16,
  parameter int SHIFT = 11,
  localparam int NH   = (TAPS + 1) / 2,
  localparam int AW   = $clog2(NH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] out_data,
  output logic          out_sat,
  input  logic          coef_we,
  input  logic [AW-1:0] coef_addr,
  input  logic [CW-1:0] coef_data,
  output logic          coef_ready,
  input  logic          flush
);

  localparam int TW   = $clog2(TAPS);
  localparam int PW   = DW + 1;
  localparam int MW   = DW + CW + 1;
  localparam int ACCW = MW + AW;

  localparam logic [AW-1:0]        IDX_LAST = AW'(NH - 1);
  localparam logic [TW-1:0]        TOP      = TW'(TAPS - 1);
  localparam logic [AW:0]          NH_W     = (AW + 1)'(NH);
  localparam logic signed [ACCW:0] RND      = (SHIFT > 0)
    ? ({{ACCW{1'b0}}, 1'b1} << (SHIFT > 0 ? SHIFT - 1 : 0)) : '0;
  localparam logic signed [ACCW:0] OMAX     = {{(ACCW + 2 - OW){1'b0}}, {(OW - 1){1'b1}}};
  localparam logic signed [ACCW:0] OMIN     = ~OMAX;

  typedef enum logic [1:0] {IDLE, MAC, ROUND, OUT} state_t;

  state_t                 state;
  logic signed [DW-1:0]   x [TAPS];
  logic signed [CW-1:0]   h [NH];
  logic signed [ACCW-1:0] acc;
  logic [AW-1:0]          idx;

  logic                   idx_last;
  logic [TW-1:0]          lo_i;
  logic [TW-1:0]          hi_i;
  logic signed [PW-1:0]   pre;
  logic signed [MW-1:0]   prod;
  logic signed [ACCW:0]   acc_ext;
  logic signed [ACCW:0]   rnd_sum;
  logic signed [ACCW:0]   r;
  logic [OW-1:0]          sat_data;
  logic                   sat_flag;

  assign in_ready   = (state == IDLE);
  assign coef_ready = (state == IDLE);
  assign out_valid  = (state == OUT);

  // The centre tap has no mirror partner; hi_i lands on it too, so its term is masked.
  always_comb begin
    idx_last = (idx == IDX_LAST);
    lo_i     = TW'(idx);
    hi_i     = TOP - TW'(idx);
    pre      = PW'(x[lo_i]) + (idx_last ? {PW{1'b0}} : PW'(x[hi_i]));
    prod     = MW'(pre) * MW'(h[idx]);
  end

  always_comb begin
    acc_ext  = (ACCW + 1)'(acc);
    rnd_sum  = acc_ext + RND;
    r        = rnd_sum >>> SHIFT;
    sat_data = r[OW-1:0];
    sat_flag = 1'b0;
    if (r > OMAX) begin
      sat_data = OMAX[OW-1:0];
      sat_flag = 1'b1;
    end else if (r < OMIN) begin
      sat_data = OMIN[OW-1:0];
      sat_flag = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      acc      <= '0;
      idx      <= '0;
      out_data <= '0;
      out_sat  <= 1'b0;
      for (int unsigned k = 0; k < TAPS; k++) x[k] <= '0;
      for (int unsigned k = 0; k < NH; k++) h[k] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (flush) begin
            for (int unsigned k = 0; k < TAPS; k++) x[k] <= '0;
          end else if (in_valid) begin
            for (int unsigned k = 1; k < TAPS; k++) x[k] <= x[k-1];
            x[0]  <= in_data;
            acc   <= '0;
            idx   <= '0;
            state <= MAC;
          end
          if (coef_we && ({1'b0, coef_addr} < NH_W)) h[coef_addr] <= coef_data;
        end
        MAC: begin
          acc <= acc + ACCW'(prod);
          idx <= idx + 1'b1;
          if (idx_last) state <= ROUND;
        end
        ROUND: begin
          out_data <= sat_data;
          out_sat  <= sat_flag;
          state    <= OUT;
        end
        OUT: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sym_fir_stream.sv
// Bench for sym_fir_stream: a 5-tap unscaled instance and a default 73-tap instance share
// stimulus; outputs are checked against a direct-convolution reference model.
module tb_sym_fir_stream;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  bit          sel = 1'b0;
  logic        in_valid = 1'b0;
  logic        coef_we = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b1;
  logic [11:0] in_data = '0;
  logic [15:0] coef_data = '0;
  logic [5:0]  coef_addr = '0;

  logic        s_in_valid, s_coef_we, s_flush;
  logic        d_in_valid, d_coef_we, d_flush;
  logic        s_in_ready, s_out_valid, s_out_sat, s_coef_ready;
  logic        d_in_ready, d_out_valid, d_out_sat, d_coef_ready;
  logic [15:0] s_out_data, d_out_data;
  logic        in_ready_m, out_valid_m, out_sat_m, coef_ready_m;
  logic [15:0] out_data_m;

  assign s_in_valid = in_valid & ~sel;
  assign d_in_valid = in_valid & sel;
  assign s_coef_we  = coef_we & ~sel;
  assign d_coef_we  = coef_we & sel;
  assign s_flush    = flush & ~sel;
  assign d_flush    = flush & sel;

  assign in_ready_m   = sel ? d_in_ready   : s_in_ready;
  assign out_valid_m  = sel ? d_out_valid  : s_out_valid;
  assign out_sat_m    = sel ? d_out_sat    : s_out_sat;
  assign coef_ready_m = sel ? d_coef_ready : s_coef_ready;
  assign out_data_m   = sel ? d_out_data   : s_out_data;

  sym_fir_stream #(.TAPS(5), .DW(12), .CW(16), .OW(16), .SHIFT(0)) u_small (
    .clk(clk), .reset(reset),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(in_data),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data), .out_sat(s_out_sat),
    .coef_we(s_coef_we), .coef_addr(coef_addr[1:0]), .coef_data(coef_data),
    .coef_ready(s_coef_ready), .flush(s_flush)
  );

  sym_fir_stream u_def (
    .clk(clk), .reset(reset),
    .in_valid(d_in_valid), .in_ready(d_in_ready), .in_data(in_data),
    .out_valid(d_out_valid), .out_ready(out_ready), .out_data(d_out_data), .out_sat(d_out_sat),
    .coef_we(d_coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .coef_ready(d_coef_ready), .flush(d_flush)
  );

  always #5 clk = ~clk;

  int     tests = 0;
  int     failed = 0;
  longint hist [2][73];
  longint hco  [2][37];

  function automatic int taps_of(input bit s);
    return s ? 73 : 5;
  endfunction

  function automatic int nh_of(input bit s);
    return (taps_of(s) + 1) / 2;
  endfunction

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear_hist(input bit s);
    for (int k = 0; k < 73; k++) hist[s][k] = 0;
  endtask

  task automatic model_push(input bit s, input longint d);
    for (int k = taps_of(s) - 1; k >= 1; k--) hist[s][k] = hist[s][k-1];
    hist[s][0] = d;
  endtask

  // y(n) = sum_k h_full[k] * x(n-k), h_full mirrored from the unique coefficients
  task automatic model_eval(input bit s, output longint y, output bit sat);
    longint acc;
    int     t;
    int     sh;
    t   = taps_of(s);
    sh  = s ? 11 : 0;
    acc = 0;
    for (int k = 0; k < t; k++)
      acc += hist[s][k] * hco[s][(k < nh_of(s)) ? k : (t - 1 - k)];
    if (sh > 0) acc = (acc + (longint'(1) << (sh - 1))) >>> sh;
    sat = 1'b0;
    y   = acc;
    if (acc > 32767) begin
      y = 32767;
      sat = 1'b1;
    end else if (acc < -32768) begin
      y = -32768;
      sat = 1'b1;
    end
  endtask

  task automatic set_coef(input bit s, input int addr, input int d, input bit accept);
    sel       = s;
    coef_we   = 1'b1;
    coef_addr = 6'(addr);
    coef_data = 16'(d);
    @(posedge clk);
    @(negedge clk);
    coef_we = 1'b0;
    if (accept && addr < nh_of(s)) hco[s][addr] = d;
  endtask

  task automatic do_flush(input bit s);
    sel   = s;
    flush = 1'b1;
    @(posedge clk);
    model_clear_hist(s);
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic run_sample(input bit s, input int d, input bit hold);
    longint ey;
    bit     es;
    int     cnt;
    sel       = s;
    in_data   = 12'(d);
    in_valid  = 1'b1;
    out_ready = !hold;
    chk("in_ready_idle", in_ready_m, 1);
    @(posedge clk);
    model_push(s, d);
    model_eval(s, ey, es);
    cnt = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid_m && cnt < 300) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
    end
    chk("latency_out_valid", cnt, nh_of(s) + 2);
    chk("out_data", $signed(out_data_m), ey);
    chk("out_sat", out_sat_m, es);
    if (!hold) begin
      while (!in_ready_m && cnt < 300) begin
        @(posedge clk);
        cnt++;
        @(negedge clk);
      end
      chk("latency_in_ready", cnt, nh_of(s) + 3);
    end else begin
      in_valid = 1'b1;
      in_data  = 12'h123;
      repeat (20) begin
        @(posedge clk);
        @(negedge clk);
        chk("bp_out_data", $signed(out_data_m), ey);
        chk("bp_out_valid", out_valid_m, 1);
        chk("bp_in_ready", in_ready_m, 0);
      end
      in_valid = 1'b0;
      chk("coef_ready_in_out", coef_ready_m, 0);
      set_coef(s, 0, 12345, 1'b0);
      chk("bp_out_data_after_we", $signed(out_data_m), ey);
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("release_out_valid", out_valid_m, 0);
      chk("release_in_ready", in_ready_m, 1);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int v;
    for (int s = 0; s < 2; s++) begin
      model_clear_hist(s[0]);
      for (int k = 0; k < 37; k++) hco[s][k] = 0;
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_s_out_valid", s_out_valid, 0);
    chk("rst_s_out_data", s_out_data, 0);
    chk("rst_s_out_sat", s_out_sat, 0);
    chk("rst_s_in_ready", s_in_ready, 1);
    chk("rst_s_coef_ready", s_coef_ready, 1);
    chk("rst_d_out_valid", d_out_valid, 0);
    chk("rst_d_out_data", d_out_data, 0);
    chk("rst_d_out_sat", d_out_sat, 0);
    chk("rst_d_in_ready", d_in_ready, 1);
    chk("rst_d_coef_ready", d_coef_ready, 1);

    // impulse through h = {1,2,3}; write to address 3 must be ignored
    set_coef(0, 0, 1, 1);
    set_coef(0, 1, 2, 1);
    set_coef(0, 2, 3, 1);
    set_coef(0, 3, 999, 1);
    run_sample(0, 100, 0);
    repeat (5) run_sample(0, 0, 0);

    // flush and a valid sample in the same cycle: flush wins, sample dropped
    sel      = 1'b0;
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 12'd77;
    chk("flush_in_ready", in_ready_m, 1);
    @(posedge clk);
    model_clear_hist(0);
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_dropped", in_ready_m, 1);

    for (int a = 0; a < 3; a++) set_coef(0, a, 1, 1);
    repeat (6) run_sample(0, 10, 0);

    for (int a = 0; a < 3; a++) set_coef(0, a, 32767, 1);
    do_flush(0);
    repeat (5) run_sample(0, 2047, 0);
    do_flush(0);
    repeat (5) run_sample(0, -2048, 0);

    // default instance: random coefficients and samples
    for (int a = 0; a < 37; a++) begin
      v = int'($urandom_range(0, 8191)) - 4096;
      set_coef(1, a, v, 1);
    end
    repeat (8) run_sample(1, int'($urandom_range(0, 4095)) - 2048, 0);
    run_sample(1, 2047, 0);
    run_sample(1, -2048, 0);
    run_sample(1, int'($urandom_range(0, 4095)) - 2048, 1);
    run_sample(1, int'($urandom_range(0, 4095)) - 2048, 0);
    run_sample(1, int'($urandom_range(0, 4095)) - 2048, 0);

    // asynchronous reset while the small instance is at idx 2 of its MAC
    sel      = 1'b0;
    in_data  = 12'd100;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("mid_mac_busy", s_in_ready, 0);
    reset = 1'b1;
    #1;
    chk("async_rst_out_valid", s_out_valid, 0);
    chk("async_rst_in_ready", s_in_ready, 1);
    chk("async_rst_coef_ready", s_coef_ready, 1);
    for (int s = 0; s < 2; s++) begin
      model_clear_hist(s[0]);
      for (int k = 0; k < 37; k++) hco[s][k] = 0;
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_sample(0, 100, 0);
    repeat (4) run_sample(0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
